sha256_ctx_seq: RTL and testbench

SHA256_CTX_SEQ -- requirements
Module: sha256_ctx_seq

---
 rtl/sha256_ctx_seq.sv | 162 ++++++++++++++++
 tb/tb_sha256_ctx_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_ctx_seq.sv
// Two-context SHA-256 block sequencer: 144 interleaved slots (2 contexts x 72 steps) per pass.
// Optional stall input enabled by defining SHA256_CTX_SEQ_STALL_EN.
module sha256_ctx_seq (
  input  logic       clk_i,
  input  logic       rst_n,
`ifdef SHA256_CTX_SEQ_STALL_EN
  input  logic       stall_i,
`endif
  input  logic       start_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       glbl_en_o,
  output logic       block2ctx_en_o,
  output logic       s1_ch_rst_o,
  output logic       s0_rst_o,
  output logic       t1_rst_o,
  output logic       d2e_en_o,
  output logic       ctx_sel_o,
  output logic [5:0] kt_addr_o,
  output logic       w_rd_en_o,
  output logic [1:0] done_o
);

  localparam int unsigned K_W  = 8;
  localparam int unsigned R_W  = 7;
  localparam int unsigned KT_W = 6;

  localparam logic [K_W-1:0] K_LAST       = K_W'(143);
  localparam logic [R_W-1:0] R_RND_FIRST  = R_W'(4);
  localparam logic [R_W-1:0] R_SAVE_FIRST = R_W'(68);
  localparam logic [R_W-1:0] R_LAST       = R_W'(71);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            glbl_en_q, glbl_en_d;
  logic            stall;

  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            load_q, load_d;
  logic            d2e_en_q, d2e_en_d;
  logic            ctx_sel_q, ctx_sel_d;
  logic [KT_W-1:0] kt_addr_q, kt_addr_d;
  logic            w_rd_en_q, w_rd_en_d;
  logic [1:0]      done_q, done_d;
  logic [R_W-1:0]  r_d;

`ifdef SHA256_CTX_SEQ_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Sequencing: a stall sampled on an edge freezes the following slot (glbl_en low, k held).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && ready_q) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (glbl_en_q) begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (!(start_i && ready_q)) begin
              state_d = S_IDLE;
            end
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
    glbl_en_d = (state_d == S_RUN) && !stall;
  end

  // Slot decode of the next k so every output register matches the slot it is shown with.
  always_comb begin
    ready_d   = 1'b0;
    busy_d    = 1'b0;
    load_d    = 1'b0;
    d2e_en_d  = 1'b0;
    ctx_sel_d = 1'b0;
    kt_addr_d = '0;
    w_rd_en_d = 1'b0;
    done_d    = 2'b00;
    r_d       = k_d[K_W-1:1];
    if (state_d == S_RUN) begin
      busy_d    = 1'b1;
      ready_d   = (k_d == K_LAST) && glbl_en_d;
      ctx_sel_d = k_d[0];
      if (r_d < R_RND_FIRST) begin
        load_d = 1'b1;
      end else if (r_d < R_SAVE_FIRST) begin
        w_rd_en_d = 1'b1;
        kt_addr_d = KT_W'(r_d - R_RND_FIRST);
      end else begin
        d2e_en_d = 1'b1;
      end
      if (glbl_en_d && (r_d == R_LAST)) begin
        done_d = k_d[0] ? 2'b10 : 2'b01;
      end
    end else begin
      ready_d = !stall;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      glbl_en_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      d2e_en_q  <= 1'b0;
      ctx_sel_q <= 1'b0;
      kt_addr_q <= '0;
      w_rd_en_q <= 1'b0;
      done_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      glbl_en_q <= glbl_en_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      d2e_en_q  <= d2e_en_d;
      ctx_sel_q <= ctx_sel_d;
      kt_addr_q <= kt_addr_d;
      w_rd_en_q <= w_rd_en_d;
      done_q    <= done_d;
    end
  end

  assign ready_o        = ready_q;
  assign busy_o         = busy_q;
  assign glbl_en_o      = glbl_en_q;
  assign block2ctx_en_o = load_q;
  assign s1_ch_rst_o    = load_q;
  assign s0_rst_o       = load_q;
  assign t1_rst_o       = load_q;
  assign d2e_en_o       = d2e_en_q;
  assign ctx_sel_o      = ctx_sel_q;
  assign kt_addr_o      = kt_addr_q;
  assign w_rd_en_o      = w_rd_en_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_sha256_ctx_seq.sv
// Directed bench for sha256_ctx_seq: slot decode per cycle plus a done-pulse scoreboard.
module tb_sha256_ctx_seq;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       stall_i;
  logic       ready_o, busy_o, glbl_en_o, block2ctx_en_o;
  logic       s1_ch_rst_o, s0_rst_o, t1_rst_o, d2e_en_o, ctx_sel_o;
  logic [5:0] kt_addr_o;
  logic       w_rd_en_o;
  logic [1:0] done_o;
  logic [17:0] outs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } done_t;
  done_t exp_q[$];
  done_t mon_e;

  sha256_ctx_seq dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
`ifdef SHA256_CTX_SEQ_STALL_EN
    .stall_i        (stall_i),
`endif
    .start_i        (start_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .glbl_en_o      (glbl_en_o),
    .block2ctx_en_o (block2ctx_en_o),
    .s1_ch_rst_o    (s1_ch_rst_o),
    .s0_rst_o       (s0_rst_o),
    .t1_rst_o       (t1_rst_o),
    .d2e_en_o       (d2e_en_o),
    .ctx_sel_o      (ctx_sel_o),
    .kt_addr_o      (kt_addr_o),
    .w_rd_en_o      (w_rd_en_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign outs = {ready_o, busy_o, glbl_en_o, block2ctx_en_o, s1_ch_rst_o, s0_rst_o,
                 t1_rst_o, d2e_en_o, ctx_sel_o, kt_addr_o, w_rd_en_o, done_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output vector from the slot table: load r0-3, rounds r4-67, save r68-71.
  function automatic logic [17:0] expv(input bit run, input int k, input bit en);
    int r;
    logic ld, wr, sv, rdy;
    logic [5:0] kt;
    logic [1:0] dn;
    if (!run) return 18'h20000;
    r   = k / 2;
    ld  = (r <= 3);
    wr  = (r >= 4) && (r <= 67);
    sv  = (r >= 68);
    kt  = wr ? 6'(r - 4) : 6'd0;
    rdy = en && (k == 143);
    dn  = 2'b00;
    if (en && k == 142) dn = 2'b01;
    if (en && k == 143) dn = 2'b10;
    return {rdy, 1'b1, en, ld, ld, ld, ld, sv, 1'(k % 2), kt, wr, dn};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_slot(input int k);
    chk($sformatf("slot_k%0d", k), 32'(outs), 32'(expv(1'b1, k, 1'b1)));
  endtask

  task automatic push_pass(input int base, input int extra);
    exp_q.push_back('{cyc: base + 143 + extra, val: 2'b01});
    exp_q.push_back('{cyc: base + 144 + extra, val: 2'b10});
  endtask

  // Pulse start for one cycle from IDLE; returns positioned on the k=0 slot.
  task automatic start_pass(input int extra, input bit expect_done);
    start_i = 1'b1;
    if (expect_done) push_pass(cyc, extra);
    step();
    start_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_n && done_o != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(done_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("done_value", 32'(done_o), 32'(mon_e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    #3;
    chk("reset_outs_async", 32'(outs), 32'd0);
    step();
    step();
    chk("reset_outs_held", 32'(outs), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));

    // Single pass
    start_pass(0, 1'b1);
    for (int k = 0; k < 144; k++) begin
      check_slot(k);
      step();
    end
    chk("idle_after_single", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));

    // Back-to-back: start held across the 143 -> 0 wrap
    start_i = 1'b1;
    push_pass(cyc, 0);
    push_pass(cyc + 144, 0);
    step();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 144; k++) begin
        check_slot(k);
        if (p == 1 && k == 143) start_i = 1'b0;
        step();
      end
    end
    chk("idle_after_b2b", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));

    // Start mid-pass is ignored
    start_pass(0, 1'b1);
    for (int k = 0; k < 144; k++) begin
      check_slot(k);
      start_i = (k == 50);
      step();
    end
    chk("idle_after_ignored", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));
    step();
    chk("ignored_not_queued", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));

    // Reset mid-pass at k=100: async clear, no done, restart at k=0
    start_pass(0, 1'b0);
    for (int k = 0; k <= 100; k++) begin
      check_slot(k);
      if (k < 100) step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midpass_reset_async", 32'(outs), 32'd0);
    step();
    step();
    chk("midpass_reset_held", 32'(outs), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_midpass_reset", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));
    start_pass(0, 1'b1);
    for (int k = 0; k < 144; k++) begin
      check_slot(k);
      step();
    end
    chk("idle_after_restart", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));

`ifdef SHA256_CTX_SEQ_STALL_EN
    // Stall for 5 cycles: slot k=20 frozen, dones shift by 5
    start_pass(5, 1'b1);
    for (int k = 0; k < 144; k++) begin
      check_slot(k);
      if (k == 19) begin
        stall_i = 1'b1;
        step();
        for (int f = 0; f < 5; f++) begin
          chk($sformatf("stall_frozen%0d", f), 32'(outs), 32'(expv(1'b1, 20, 1'b0)));
          if (f == 4) stall_i = 1'b0;
          step();
        end
      end else begin
        step();
      end
    end
    chk("idle_after_stall", 32'(outs), 32'(expv(1'b0, 0, 1'b0)));
`endif

    step();
    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
